// File: rtl/aisys_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aisys_pkg
// Purpose  : Shared transfer-controller state encoding and word geometry.
// Revision : 1.0 - initial release
// ============================================================================
package aisys_pkg;

  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RX_BYTE  = 3'd1,
    ST_RX_WRITE = 3'd2,
    ST_TX_READ  = 3'd3,
    ST_TX_LAT   = 3'd4,
    ST_TX_BYTE  = 3'd5,
    ST_DONE     = 3'd6
  } xfer_state_t;

endpackage
`default_nettype wire

// File: rtl/xfer_word_pack.sv
`default_nettype none
// ============================================================================
// Module   : xfer_word_pack
// Purpose  : 32-bit little-endian pack/unpack register with its byte index,
//            shared by the receive and transmit paths.
// Revision : 1.0 - initial release
// ============================================================================
module xfer_word_pack
  import aisys_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        rx_push,
  input  logic [7:0]  rx_byte,
  input  logic        load,
  input  logic [31:0] load_word,
  input  logic        tx_adv,
  output logic [31:0] word,
  output logic [7:0]  byte_out,
  output logic [1:0]  byte_idx,
  output logic        last_byte
);

  logic [31:0] r_word;
  logic [1:0]  r_idx;

  // clr wins over load, which wins over the per-byte operations
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (clr) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (load) begin
      r_word <= load_word;
      r_idx  <= '0;
    end else if (rx_push) begin
      r_word[{r_idx, 3'b000} +: 8] <= rx_byte;
      r_idx                        <= r_idx + 2'd1;
    end else if (tx_adv) begin
      r_idx <= r_idx + 2'd1;
    end
  end

  assign word      = r_word;
  assign byte_out  = r_word[{r_idx, 3'b000} +: 8];
  assign byte_idx  = r_idx;
  assign last_byte = (r_idx == 2'(BYTES_PER_WORD - 1));

endmodule
`default_nettype wire

// File: rtl/uart_xfer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_xfer_ctrl
// Purpose  : Moves XFER_WORDS 32-bit words between a byte UART and a word
//            buffer memory, in either direction, on a uart_en rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module uart_xfer_ctrl
  import aisys_pkg::*;
#(
  parameter int XFER_WORDS = 16,
  parameter int ADDR_W     = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_en,
  input  logic              uart_wrSel,
  output logic              uart_done,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int C_CNT_W = $clog2(XFER_WORDS + 1);
  localparam logic [C_CNT_W-1:0] C_LAST_CNT = C_CNT_W'(XFER_WORDS);

  xfer_state_t        r_state;
  xfer_state_t        w_state_nxt;
  logic               r_en_d;
  logic [C_CNT_W-1:0] r_count;
  logic [ADDR_W-1:0]  r_addr;

  logic               w_start;
  logic               w_step;
  logic               w_clr;
  logic               w_push;
  logic               w_load;
  logic               w_adv;
  logic [C_CNT_W-1:0] w_count_inc;
  logic               w_last_word;
  logic [31:0]        w_word;
  logic [7:0]         w_byte;
  logic [1:0]         w_byte_idx;
  logic               w_last_byte;

  xfer_word_pack u_pack (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (w_clr),
    .rx_push   (w_push),
    .rx_byte   (rx_data),
    .load      (w_load),
    .load_word (mem_rdata),
    .tx_adv    (w_adv),
    .word      (w_word),
    .byte_out  (w_byte),
    .byte_idx  (w_byte_idx),
    .last_byte (w_last_byte)
  );

  assign w_count_inc = r_count + 1'b1;
  assign w_last_word = (w_count_inc == C_LAST_CNT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Direction is captured by the branch taken at start, so later wrSel
  // changes cannot redirect a transfer in progress.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_step      = 1'b0;
    w_clr       = 1'b0;
    w_push      = 1'b0;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    mem_we      = 1'b0;
    tx_valid    = 1'b0;
    uart_done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (uart_en && !r_en_d) begin
          w_start     = 1'b1;
          w_clr       = 1'b1;
          w_state_nxt = uart_wrSel ? ST_RX_BYTE : ST_TX_READ;
        end
      end
      ST_RX_BYTE: begin
        if (!uart_en) begin
          w_state_nxt = ST_IDLE;
        end else if (rx_valid) begin
          w_push = 1'b1;
          if (w_last_byte) w_state_nxt = ST_RX_WRITE;
        end
      end
      ST_RX_WRITE: begin
        if (!uart_en) begin
          w_state_nxt = ST_IDLE;
        end else begin
          mem_we      = 1'b1;
          w_step      = 1'b1;
          w_state_nxt = w_last_word ? ST_DONE : ST_RX_BYTE;
        end
      end
      ST_TX_READ: begin
        w_state_nxt = uart_en ? ST_TX_LAT : ST_IDLE;
      end
      ST_TX_LAT: begin
        if (!uart_en) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_load      = 1'b1;
          w_state_nxt = ST_TX_BYTE;
        end
      end
      ST_TX_BYTE: begin
        if (!uart_en) begin
          w_state_nxt = ST_IDLE;
        end else begin
          tx_valid = 1'b1;
          if (tx_ready) begin
            w_adv = 1'b1;
            if (w_last_byte) begin
              w_step      = 1'b1;
              w_state_nxt = w_last_word ? ST_DONE : ST_TX_READ;
            end
          end
        end
      end
      ST_DONE: begin
        uart_done   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_en_d  <= 1'b0;
      r_count <= '0;
      r_addr  <= '0;
    end else begin
      r_en_d <= uart_en;
      if (w_start) begin
        r_count <= '0;
        r_addr  <= ADDR_W'(BASE_ADDR);
      end else if (w_step) begin
        r_count <= w_count_inc;
        r_addr  <= r_addr + 1'b1;
      end
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = w_word;
  assign tx_data   = w_byte;

endmodule
`default_nettype wire
